// File: rtl/store_queue_pkg.sv
// Shared types for the store queue: entry layout, execute/dcache packets.
// Also holds the byte-lane helpers used by forwarding.
package store_queue_pkg;

  localparam int SQ_IDX_BITS  = 3;
  localparam int N            = 2;
  localparam int NUM_FU_LOAD  = 2;
  localparam int NUM_FU_STORE = 2;

  typedef logic [2:0] mem_func_t;

  localparam mem_func_t MEM_B  = 3'b000;
  localparam mem_func_t MEM_H  = 3'b001;
  localparam mem_func_t MEM_W  = 3'b010;
  localparam mem_func_t MEM_BU = 3'b100;
  localparam mem_func_t MEM_HU = 3'b101;

  typedef struct packed {
    logic        valid;
    logic        addr_valid;
    logic [31:0] addr;
    logic [31:0] data;
    mem_func_t   mem_func;
  } sq_entry_t;

  typedef struct packed {
    logic                   valid;
    logic [SQ_IDX_BITS-1:0] sq_idx;
    logic [31:0]            base;
    logic [11:0]            offset;
    logic [31:0]            data;
    mem_func_t              mem_func;
  } rs_sq_packet_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
    mem_func_t   mem_func;
  } sq_dcache_packet_t;

  function automatic logic [3:0] byte_mask(
    input logic [1:0] sz,
    input logic [1:0] a
  );
    logic [3:0] m;
    m = 4'b1111;
    unique case (1'b1)
      (sz == 2'b00): m = 4'b0001 << a;
      (sz == 2'b01): m = 4'b0011 << {a[1], 1'b0};
      default:       m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [1:0] lane_base(
    input logic [1:0] sz,
    input logic [1:0] a
  );
    logic [1:0] b;
    b = 2'b00;
    unique case (1'b1)
      (sz == 2'b00): b = a;
      (sz == 2'b01): b = {a[1], 1'b0};
      default:       b = 2'b00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/store_queue_if.sv
// Dcache drain handshake: the queue offers its head store, dcache accepts.
// Packet is held stable while valid and not accepted.
interface store_queue_if;
  import store_queue_pkg::*;

  sq_dcache_packet_t sq_dcache_packet;
  logic              store_req_accept;

  modport master (
    output sq_dcache_packet,
    input  store_req_accept
  );

  modport slave (
    input  sq_dcache_packet,
    output store_req_accept
  );

endinterface

// File: rtl/sq_fwd_unit.sv
// Per-load-port forwarding: youngest older matching store per byte lane.
// Purely combinational over the pre-edge entry array.
module sq_fwd_unit
  import store_queue_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int IW    = $clog2(DEPTH)
) (
  input  sq_entry_t [DEPTH-1:0] entries,
  input  logic [IW-1:0]         head,
  input  logic [IW-1:0]         store_range,
  input  logic [31:0]           addr,
  input  mem_func_t             mem_func,
  output logic [31:0]           value,
  output logic                  fwd_valid,
  output logic                  fwd_partial
);

  logic [IW-1:0] len;
  logic [IW-1:0] idx;
  logic [3:0]    need;
  logic [3:0]    cov;
  logic [3:0]    m;
  logic [31:0]   sd;
  logic          hit;
  logic          unused_sign;

  // Sign/zero extension is the load unit's job.
  assign unused_sign = mem_func[2];

  // Oldest to youngest, so later matches overwrite earlier ones.
  always_comb begin
    len   = store_range - head;
    need  = byte_mask(mem_func[1:0], addr[1:0]);
    value = '0;
    cov   = '0;
    idx   = '0;
    m     = '0;
    sd    = '0;
    hit   = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + IW'(k);
      m   = byte_mask(entries[idx].mem_func[1:0],
                      entries[idx].addr[1:0]);
      sd  = entries[idx].data << {lane_base(
              entries[idx].mem_func[1:0],
              entries[idx].addr[1:0]), 3'b000};
      hit = (IW'(k) < len)
          && entries[idx].valid
          && entries[idx].addr_valid
          && (entries[idx].addr[31:2] == addr[31:2]);
      for (int l = 0; l < 4; l++) begin
        if (hit && m[l] && need[l]) begin
          value[8*l +: 8] = sd[8*l +: 8];
          cov[l]          = 1'b1;
        end
      end
    end
    fwd_valid   = (cov == need);
    fwd_partial = (|cov) && (cov != need);
  end

endmodule

// File: rtl/store_queue.sv
// In-order store queue: dispatch, execute, commit, squash, dcache drain, forwarding.
// Define SQ_DEBUG_EN to expose entries_out, head_out, commit_out, tail_out.
module store_queue
  import store_queue_pkg::*;
#(
  parameter  int DEPTH    = 2 ** SQ_IDX_BITS,
  parameter  int NUM_DISP = N,
  parameter  int NUM_LD   = NUM_FU_LOAD,
  parameter  int NUM_ST   = NUM_FU_STORE,
  localparam int IW       = $clog2(DEPTH),
  localparam int DW       = $clog2(NUM_DISP + 1)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [DW-1:0]                  dispatch_num,
  output logic [IW-1:0]                  sq_free,
  output logic [IW-1:0]                  tail_store,
  input  rs_sq_packet_t [NUM_ST-1:0]     rs_sq_packet,
  input  logic [NUM_LD-1:0][31:0]        sq_addr,
  input  logic [NUM_LD-1:0][IW-1:0]      store_range,
  input  mem_func_t [NUM_LD-1:0]         load_byte_info,
  output logic [NUM_LD-1:0][31:0]        value,
  output logic [NUM_LD-1:0]              fwd_valid,
  output logic [NUM_LD-1:0]              fwd_partial,
  input  logic [DW-1:0]                  commit_num,
  input  logic                           squash,
  store_queue_if.master                  dcache
`ifdef SQ_DEBUG_EN
  ,
  output sq_entry_t [DEPTH-1:0]          entries_out,
  output logic [IW-1:0]                  head_out,
  output logic [IW-1:0]                  commit_out,
  output logic [IW-1:0]                  tail_out
`endif
);

  sq_entry_t [DEPTH-1:0] entries;
  sq_entry_t [DEPTH-1:0] entries_nx;
  logic [IW-1:0]         head;
  logic [IW-1:0]         commit_ptr;
  logic [IW-1:0]         tail;
  logic [IW-1:0]         count;
  logic [IW-1:0]         head_nx;
  logic [IW-1:0]         commit_nx;
  logic [IW-1:0]         tail_nx;
  logic [IW-1:0]         count_nx;
  logic [IW-1:0]         rel;
  logic [IW-1:0]         slot;
  logic                  retire;

  // Committed region is at most DEPTH-1, so head == commit_ptr means none.
  assign dcache.sq_dcache_packet = '{
    valid:    (head != commit_ptr),
    addr:     entries[head].addr,
    data:     entries[head].data,
    mem_func: entries[head].mem_func
  };

  assign retire     = dcache.sq_dcache_packet.valid
                    && dcache.store_req_accept;
  assign sq_free    = IW'(DEPTH - 1) - count;
  assign tail_store = tail;

  always_comb begin
    head_nx   = head + IW'(retire);
    commit_nx = commit_ptr + IW'(commit_num);
    if (squash) begin
      tail_nx  = commit_nx;
      count_nx = commit_nx - head_nx;
    end else begin
      tail_nx  = tail + IW'(dispatch_num);
      count_nx = count + IW'(dispatch_num) - IW'(retire);
    end
  end

  always_comb begin
    entries_nx = entries;
    rel        = '0;
    slot       = '0;
    if (retire) begin
      entries_nx[head] = '0;
    end
    if (!squash) begin
      for (int k = 0; k < NUM_DISP; k++) begin
        if (DW'(k) < dispatch_num) begin
          slot                   = tail + IW'(k);
          entries_nx[slot]       = '0;
          entries_nx[slot].valid = 1'b1;
        end
      end
    end
    for (int p = 0; p < NUM_ST; p++) begin
      if (rs_sq_packet[p].valid) begin
        slot = IW'(rs_sq_packet[p].sq_idx);
        entries_nx[slot].addr       = rs_sq_packet[p].base
                                    + {20'b0, rs_sq_packet[p].offset};
        entries_nx[slot].data       = rs_sq_packet[p].data;
        entries_nx[slot].mem_func   = rs_sq_packet[p].mem_func;
        entries_nx[slot].addr_valid = 1'b1;
      end
    end
    // Survivors of a squash are exactly the committed, unretired ones.
    if (squash) begin
      for (int i = 0; i < DEPTH; i++) begin
        rel = IW'(i) - head_nx;
        if (rel >= count_nx) begin
          entries_nx[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head       <= '0;
      commit_ptr <= '0;
      tail       <= '0;
      count      <= '0;
      entries    <= '0;
    end else begin
      head       <= head_nx;
      commit_ptr <= commit_nx;
      tail       <= tail_nx;
      count      <= count_nx;
      entries    <= entries_nx;
    end
  end

  for (genvar l = 0; l < NUM_LD; l++) begin : g_fwd
    sq_fwd_unit #(
      .DEPTH(DEPTH)
    ) u_fwd (
      .entries    (entries),
      .head       (head),
      .store_range(store_range[l]),
      .addr       (sq_addr[l]),
      .mem_func   (load_byte_info[l]),
      .value      (value[l]),
      .fwd_valid  (fwd_valid[l]),
      .fwd_partial(fwd_partial[l])
    );
  end

`ifdef SQ_DEBUG_EN
  assign entries_out = entries;
  assign head_out    = head;
  assign commit_out  = commit_ptr;
  assign tail_out    = tail;
`endif

endmodule

// File: tb/tb_store_queue.sv
// Bench for store_queue: directed cases with literal expectations,
// then randomized traffic against a program-order queue model.
module tb_store_queue;
  import store_queue_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [1:0]             dispatch_num;
  logic [2:0]             sq_free;
  logic [2:0]             tail_store;
  rs_sq_packet_t [1:0]    rs;
  logic [1:0][31:0]       sq_addr;
  logic [1:0][2:0]        store_range;
  mem_func_t [1:0]        load_byte_info;
  logic [1:0][31:0]       value;
  logic [1:0]             fwd_valid;
  logic [1:0]             fwd_partial;
  logic [1:0]             commit_num;
  logic                   squash;

  store_queue_if dc_if ();

`ifdef SQ_DEBUG_EN
  sq_entry_t [7:0] entries_out;
  logic [2:0]      head_out;
  logic [2:0]      commit_out;
  logic [2:0]      tail_out;
`endif

  store_queue dut (
    .clock         (clock),
    .reset         (reset),
    .dispatch_num  (dispatch_num),
    .sq_free       (sq_free),
    .tail_store    (tail_store),
    .rs_sq_packet  (rs),
    .sq_addr       (sq_addr),
    .store_range   (store_range),
    .load_byte_info(load_byte_info),
    .value         (value),
    .fwd_valid     (fwd_valid),
    .fwd_partial   (fwd_partial),
    .commit_num    (commit_num),
    .squash        (squash),
    .dcache        (dc_if)
`ifdef SQ_DEBUG_EN
    ,
    .entries_out   (entries_out),
    .head_out      (head_out),
    .commit_out    (commit_out),
    .tail_out      (tail_out)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: stores in program order, oldest first; first m_nc are committed.
  typedef struct {
    bit        av;
    bit [31:0] addr;
    bit [31:0] data;
    bit [2:0]  f;
  } ms_t;

  ms_t q[$];
  int  m_head = 0;
  int  m_nc   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_head = 0;
    m_nc   = 0;
  endtask

  // Each byte of the load looks for the youngest older store containing it.
  function automatic void mfwd(input logic [31:0] la, input logic [2:0] lf,
                               input int rng, output logic [31:0] v,
                               output logic fv, output logic fp);
    int sz, len, cov, ss;
    bit found;
    logic [31:0] ls, ba, st;
    logic [7:0] bv;
    sz  = 1 << lf[1:0];
    len = ((rng - m_head) % 8 + 8) % 8;
    ls  = la & ~32'(sz - 1);
    v   = 0;
    cov = 0;
    for (int b = 0; b < sz; b++) begin
      ba    = ls + 32'(b);
      found = 0;
      bv    = 0;
      for (int p = 0; p < len && p < q.size(); p++) begin
        if (q[p].av) begin
          ss = 1 << q[p].f[1:0];
          st = q[p].addr & ~32'(ss - 1);
          if (ba >= st && ba < st + 32'(ss)) begin
            bv    = 8'(q[p].data >> (8 * (ba - st)));
            found = 1;
          end
        end
      end
      if (found) begin
        v = v | (32'(bv) << (8 * (ba % 4)));
        cov++;
      end
    end
    fv = (cov == sz);
    fp = (cov > 0 && cov < sz);
  endfunction

  task automatic check_model();
    logic [31:0] v;
    logic fv, fp;
    chk("sq_free", 32'(sq_free), 32'(7 - q.size()));
    chk("tail_store", 32'(tail_store), 32'((m_head + q.size()) % 8));
    chk("dc_valid", 32'(dc_if.sq_dcache_packet.valid), (m_nc > 0) ? 1 : 0);
    if (m_nc > 0) begin
      chk("dc_addr", dc_if.sq_dcache_packet.addr, q[0].addr);
      chk("dc_data", dc_if.sq_dcache_packet.data, q[0].data);
      chk("dc_func", 32'(dc_if.sq_dcache_packet.mem_func), 32'(q[0].f));
    end
    for (int l = 0; l < 2; l++) begin
      mfwd(sq_addr[l], load_byte_info[l], int'(store_range[l]), v, fv, fp);
      chk("fwd_value", value[l], v);
      chk("fwd_valid", 32'(fwd_valid[l]), 32'(fv));
      chk("fwd_partial", 32'(fwd_partial[l]), 32'(fp));
    end
  endtask

  task automatic model_step();
    bit ret;
    int pos;
    ms_t blank;
    blank = '{av: 0, addr: 0, data: 0, f: 0};
    ret = (m_nc > 0) && dc_if.store_req_accept;
    for (int p = 0; p < 2; p++) begin
      if (rs[p].valid) begin
        pos = ((int'(rs[p].sq_idx) - m_head) % 8 + 8) % 8;
        if (pos < q.size()) begin
          q[pos].av   = 1;
          q[pos].addr = rs[p].base + 32'(rs[p].offset);
          q[pos].data = rs[p].data;
          q[pos].f    = rs[p].mem_func;
        end
      end
    end
    m_nc += int'(commit_num);
    if (ret) begin
      void'(q.pop_front());
      m_head = (m_head + 1) % 8;
      m_nc--;
    end
    if (squash) begin
      while (q.size() > m_nc) void'(q.pop_back());
    end else begin
      for (int k = 0; k < int'(dispatch_num); k++) q.push_back(blank);
    end
  endtask

  task automatic clear_inputs();
    dispatch_num = '0;
    commit_num   = '0;
    squash       = 1'b0;
    rs           = '0;
  endtask

  task automatic cycle();
    #1;
    check_model();
    @(posedge clock);
    model_step();
    @(negedge clock);
    clear_inputs();
  endtask

  task automatic set_exec(input int port, input int idx, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] f);
    logic [11:0] off;
    off = 12'($urandom_range(0, 4095));
    rs[port].valid    = 1'b1;
    rs[port].sq_idx   = 3'(idx);
    rs[port].base     = a - 32'(off);
    rs[port].offset   = off;
    rs[port].data     = d;
    rs[port].mem_func = f;
  endtask

  task automatic query(input int l, input logic [31:0] a,
                       input logic [2:0] f, input int r);
    sq_addr[l]        = a;
    load_byte_info[l] = f;
    store_range[l]    = 3'(r);
  endtask

  task automatic gen_random();
    int sz, fr, ne, k, lim, r;
    sz = q.size();
    fr = 7 - sz;
    squash = ($urandom_range(0, 19) == 0);
    lim = (fr < 2) ? fr : 2;
    dispatch_num = 2'($urandom_range(0, lim));
    ne = 0;
    for (int p = m_nc; p < sz; p++) begin
      if (!q[p].av && ne < 2 && $urandom_range(0, 1) == 1) begin
        set_exec(ne, (m_head + p) % 8, 32'h100 + $urandom_range(0, 15),
                 $urandom, 3'($urandom_range(0, 2)));
        ne++;
      end
    end
    k = 0;
    while (m_nc + k < sz && q[m_nc + k].av) k++;
    lim = (k < 2) ? k : 2;
    commit_num = 2'($urandom_range(0, lim));
    dc_if.store_req_accept = ($urandom_range(0, 9) < 7);
    for (int l = 0; l < 2; l++) begin
      r = $urandom_range(0, 4);
      query(l, 32'h100 + $urandom_range(0, 15),
            (r < 3) ? 3'(r) : 3'(r + 1),
            (m_head + $urandom_range(0, sz)) % 8);
    end
  endtask

  initial begin
    clear_inputs();
    dc_if.store_req_accept = 1'b0;
    query(0, 32'h0, MEM_W, 0);
    query(1, 32'h0, MEM_W, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();

    #1;
    chk("reset_sq_free", 32'(sq_free), 32'd7);
    chk("reset_tail", 32'(tail_store), 32'd0);
    chk("reset_dc_valid", 32'(dc_if.sq_dcache_packet.valid), 32'd0);
    chk("reset_fwd_valid", 32'(fwd_valid), 32'd0);
    chk("reset_value", value[0], 32'd0);

    // Simple full-word forward
    dispatch_num = 2;
    cycle();
    set_exec(0, 0, 32'h100, 32'hDEADBEEF, MEM_W);
    cycle();
    query(0, 32'h100, MEM_W, 2);
    #1;
    chk("sw_fwd_value", value[0], 32'hDEADBEEF);
    chk("sw_fwd_valid", 32'(fwd_valid[0]), 32'd1);
    cycle();

    // Youngest store wins per lane
    set_exec(0, 0, 32'h100, 32'h11223344, MEM_W);
    set_exec(1, 1, 32'h101, 32'h000000AA, MEM_B);
    cycle();
    query(0, 32'h100, MEM_W, 2);
    query(1, 32'h100, MEM_W, 1);
    #1;
    chk("young_value", value[0], 32'h1122AA44);
    chk("young_valid", 32'(fwd_valid[0]), 32'd1);
    chk("range1_value", value[1], 32'h11223344);
    cycle();

    // Async reset while holding three entries, one committed
    dispatch_num = 1;
    commit_num   = 1;
    cycle();
    #1;
    chk("pre_reset_dc_valid", 32'(dc_if.sq_dcache_packet.valid), 32'd1);
    chk("pre_reset_dc_data", dc_if.sq_dcache_packet.data, 32'h11223344);
    chk("pre_reset_sq_free", 32'(sq_free), 32'd4);
    reset = 1'b1;
    #1;
    chk("async_sq_free", 32'(sq_free), 32'd7);
    chk("async_tail", 32'(tail_store), 32'd0);
    chk("async_dc_valid", 32'(dc_if.sq_dcache_packet.valid), 32'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;

    // Partial coverage
    dispatch_num = 1;
    cycle();
    set_exec(0, 0, 32'h100, 32'h00000055, MEM_B);
    cycle();
    query(0, 32'h100, MEM_W, 1);
    query(1, 32'h102, MEM_BU, 1);
    #1;
    chk("part_value", value[0], 32'h00000055);
    chk("part_valid", 32'(fwd_valid[0]), 32'd0);
    chk("part_partial", 32'(fwd_partial[0]), 32'd1);
    chk("miss_valid", 32'(fwd_valid[1]), 32'd0);
    chk("miss_partial", 32'(fwd_partial[1]), 32'd0);
    chk("miss_value", value[1], 32'd0);
    cycle();

    // Retire with stall
    commit_num = 1;
    cycle();
    repeat (3) begin
      #1;
      chk("stall_dc_valid", 32'(dc_if.sq_dcache_packet.valid), 32'd1);
      chk("stall_dc_addr", dc_if.sq_dcache_packet.addr, 32'h100);
      chk("stall_dc_data", dc_if.sq_dcache_packet.data, 32'h55);
      chk("stall_sq_free", 32'(sq_free), 32'd6);
      cycle();
    end
    dc_if.store_req_accept = 1'b1;
    cycle();
    #1;
    chk("retired_sq_free", 32'(sq_free), 32'd7);
    chk("retired_tail", 32'(tail_store), 32'd1);
    chk("retired_dc_valid", 32'(dc_if.sq_dcache_packet.valid), 32'd0);

    // Walk head round to 6
    for (int i = 1; i <= 5; i++) begin
      dispatch_num = 1;
      cycle();
      set_exec(0, i, 32'h300 + 32'(4 * i), 32'(i), MEM_W);
      cycle();
      commit_num = 1;
      cycle();
      cycle();
    end
    dc_if.store_req_accept = 1'b0;
    #1;
    chk("walk_tail", 32'(tail_store), 32'd6);

    // Wrap plus squash
    dispatch_num = 2;
    cycle();
    dispatch_num = 2;
    cycle();
    set_exec(0, 6, 32'h104, 32'hCAFEF00D, MEM_W);
    set_exec(1, 7, 32'h106, 32'h0000BEEF, MEM_H);
    cycle();
    commit_num = 1;
    cycle();
    #1;
    chk("wrap_sq_free", 32'(sq_free), 32'd3);
    chk("wrap_tail", 32'(tail_store), 32'd2);
    squash = 1'b1;
    set_exec(0, 0, 32'h104, 32'h12345678, MEM_W);
    cycle();
    #1;
    chk("squash_tail", 32'(tail_store), 32'd7);
    chk("squash_sq_free", 32'(sq_free), 32'd6);
    squash       = 1'b1;
    dispatch_num = 2;
    cycle();
    #1;
    chk("squash_disp_tail", 32'(tail_store), 32'd7);
    chk("squash_disp_free", 32'(sq_free), 32'd6);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) begin
        #1;
        reset = 1'b1;
        #1;
        chk("mid_reset_free", 32'(sq_free), 32'd7);
        chk("mid_reset_dc_valid", 32'(dc_if.sq_dcache_packet.valid), 32'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
      end
      gen_random();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/store_queue.md
# store_queue

Holds in-flight stores in program order, from dispatch through commit to dcache write-back, and answers byte-granular store-to-load forwarding queries. It feeds the load queue: each cycle the load queue presents a load's address, size and `tail_store` range, and this block returns forwarded data plus a validity flag in the same cycle. Committed stores drain from the head to the dcache, one per cycle, under a valid/accept handshake.

## Interface
- `DEPTH`, default 2**`SQ_IDX_BITS` (8): number of entries; must be a power of two; usable capacity is DEPTH-1.
- `NUM_DISP`, default `N`: stores allocated per cycle (max).
- `NUM_LD`, default `NUM_FU_LOAD`: number of forwarding query ports.
- `NUM_ST`, default `NUM_FU_STORE`: number of store-execute ports.

- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `dispatch_num` in clog2(NUM_DISP+1): stores allocated this cycle; must not exceed `sq_free`.
- `sq_free` out clog2(DEPTH): free entries, range 0..DEPTH-1.
- `tail_store` out `SQ_IDX_BITS`: current tail; dispatch records it with each load and store.
- `rs_sq_packet` in NUM_ST x RS_SQ_PACKET: {valid, sq_idx, base, offset[11:0], data, mem_func}.
- `sq_addr` in NUM_LD x ADDR: load address.
- `store_range` in NUM_LD x `SQ_IDX_BITS`: the load's recorded tail; the stores older than the load are the entries from head to store_range-1.
- `load_byte_info` in NUM_LD x MEM_FUNC: load size.
- `value` out NUM_LD x DATA: forwarded word, with bytes in their natural lanes.
- `fwd_valid` out NUM_LD: every byte of the load is covered by older stores.
- `fwd_partial` out NUM_LD: some bytes are covered, but not all.
- `commit_num` in clog2(NUM_DISP+1): number of stores the ROB commits this cycle.
- `squash` in 1: mispredict; discards all uncommitted entries.
- `sq_dcache_packet` out SQ_DCACHE_PACKET: {valid, addr, data, mem_func}.
- `store_req_accept` in 1: dcache accepts the head store.

## Operation
**Pointers.** `head`, `commit_ptr` and `tail` are each `SQ_IDX_BITS` wide and wrap modulo DEPTH.
- A count register (0..DEPTH-1) disambiguates full from empty.
- `sq_free` = DEPTH-1-count.

**Dispatch.** Entries tail..tail+dispatch_num-1 are cleared to {valid=1, addr_valid=0}, and tail advances by dispatch_num.

**Execute.** For each valid `rs_sq_packet` port:
- entry[sq_idx] is written with addr = base + zero-extended offset, data, mem_func, addr_valid=1.
- The RS guarantees distinct sq_idx values across ports.

**Forwarding (combinational, per load port).**
- Scan entries head..store_range-1. The range length is (store_range-head) mod DEPTH; 0 means no older stores.
- For each byte lane the load needs, the youngest in-range addr_valid store whose word address matches and whose byte mask covers that lane supplies the byte.
- Byte masks: BYTE = 1 lane at addr[1:0]; HALF = 2 lanes at {addr[1],0}; WORD = all 4 lanes.
- `fwd_valid` = all needed lanes covered. `fwd_partial` = some covered, not all.
- Uncovered lanes of `value` are 0.
- Entries without addr_valid are ignored; the RS issues a load only after all of its older stores have executed.

**Commit.** `commit_ptr` advances by commit_num. Entries from head up to commit_ptr are committed.

**Retire.**
- `sq_dcache_packet.valid` = (head != commit_ptr, or count is nonzero with the head entry committed).
- The packet carries the head entry's addr, data and mem_func.
- On `store_req_accept` with valid: the head entry is invalidated and head advances by 1.

**Squash.** tail <= commit_ptr. Count is recomputed from committed entries. Uncommitted entries are invalidated.

**Simultaneous events.**
- Squash overrides dispatch in the same cycle.
- Commit and retire in the same cycle as a squash still apply; squash uses the post-commit commit_ptr.
- Execute writes to squashed indices are dropped.

## Timing
- Dispatch, execute, commit, squash and retire updates are visible on the cycle after the edge on which they are sampled.
- Forwarding has 0-cycle latency and sees only pre-edge state: a store executing in the same cycle is not forwarded.
- `sq_dcache_packet` is held stable while valid && !accept.
- Reset values:
  - all entries invalid
  - head = commit_ptr = tail = 0
  - `sq_free` = DEPTH-1
  - `tail_store` = 0
  - `sq_dcache_packet.valid` = 0
  - `fwd_valid` = `fwd_partial` = 0, `value` = 0
- Reset asserted mid-operation drops all entries, including committed ones, and takes effect immediately (asynchronous).

## Configuration
- `SQ_DEBUG_EN`:
  - Defined: adds output `entries_out` (DEPTH x SQ_ENTRY) plus `head_out`, `commit_out` and `tail_out`.
  - Undefined: these ports and their logic are absent, and functional behaviour is identical.

## Structure
- In `sys_defs.svh`: SQ_ENTRY {valid, addr_valid, addr, data, mem_func}, RS_SQ_PACKET, SQ_DCACHE_PACKET. `SQ_IDX_BITS` is already there.
- Sub-module `sq_fwd_unit`, one instance per load port:
  - inputs: entries, head, store_range, addr, mem_func
  - outputs: value, fwd_valid, fwd_partial
  - performs the per-lane youngest-match scan.

## Test plan
- Reset while holding 3 entries -> `sq_free`=7, `tail_store`=0, `sq_dcache_packet.valid`=0 on the same cycle reset asserts.
- Dispatch 2 stores; execute idx0 sw 0x100=0xDEADBEEF; query lw 0x100 with range=2 -> `fwd_valid`=1, `value`=0xDEADBEEF.
- Youngest wins: idx0 sw 0x100=0x11223344, idx1 sb 0x101=0xAA; query lw 0x100 with range=2 -> `value`=0x1122AA44, `fwd_valid`=1; same query with range=1 -> `value`=0x11223344.
- Partial coverage: only sb 0x100=0x55 in range; query lw 0x100 -> `fwd_valid`=0, `fwd_partial`=1, `value`=0x00000055; query lbu 0x102 -> both flags 0.
- Retire with stall: commit 1, hold `store_req_accept`=0 for 3 cycles -> packet stable and `sq_free` unchanged; assert accept -> next cycle head+1 and `sq_free`+1.
- Wrap plus squash: head=6, 4 entries (idx 6,7,0,1), commit 1, then squash -> `tail_store`=7, `sq_free`=6; squash in the same cycle as dispatch_num=2 -> dispatch ignored.
